// File: rtl/ifu_compress_pack.sv
`default_nettype none
// ============================================================================
// Module   : ifu_compress_pack
// Brief    : Re-encodes RV64 instructions into 16-bit RVC form where an exact
//            equivalent exists and packs the halfword stream little-endian
//            into 32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_compress_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             idle,
    output logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_cmp
);

    localparam logic [15:0] c_HALF_NOP    = 16'h0001;
    localparam logic [15:0] c_HALF_EBREAK = 16'h9002;
    localparam logic [31:0] c_WORD_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_WORD_EBREAK = 32'h0010_0073;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Instruction fields
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_f7;
    logic [11:0] w_imm_i;
    logic [11:0] w_imm_s;
    logic        w_imm6_ok;
    logic        w_rd_c;
    logic        w_rs1_c;
    logic        w_rs2_c;

    // Compressor result: w_hit means the accepted item yields one halfword
    logic        w_hit;
    logic [15:0] w_half;

    // State
    logic             r_hold_v_q,    w_hold_v_d;
    logic [15:0]      r_hold_q,      w_hold_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [31:0]      r_out_data_q,  w_out_data_d;
    logic [CNT_W-1:0] r_cnt_in_q,    w_cnt_in_d;
    logic [CNT_W-1:0] r_cnt_cmp_q,   w_cnt_cmp_d;

    logic w_slot_free;
    logic w_accept;

    assign w_op      = in_data[6:0];
    assign w_rd      = in_data[11:7];
    assign w_f3      = in_data[14:12];
    assign w_rs1     = in_data[19:15];
    assign w_rs2     = in_data[24:20];
    assign w_f7      = in_data[31:25];
    assign w_imm_i   = in_data[31:20];
    assign w_imm_s   = {in_data[31:25], in_data[11:7]};
    // Immediate fits the 6-bit signed RVC field when bits [11:5] are a pure sign extension
    assign w_imm6_ok = (w_imm_i[11:5] == 7'h00) || (w_imm_i[11:5] == 7'h7F);
    // Register lies in the x8..x15 window reachable by 3-bit RVC register fields
    assign w_rd_c    = (w_rd[4:3]  == 2'b01);
    assign w_rs1_c   = (w_rs1[4:3] == 2'b01);
    assign w_rs2_c   = (w_rs2[4:3] == 2'b01);

    // Find the exact 16-bit equivalent of the offered instruction, if any
    always_comb begin
        w_hit  = 1'b0;
        w_half = 16'h0000;
        if (in_data[1:0] != 2'b11) begin
            w_hit  = 1'b1;
            w_half = in_data[15:0];
        end else if (in_data == c_WORD_NOP) begin
            w_hit  = 1'b1;
            w_half = c_HALF_NOP;
        end else if (in_data == c_WORD_EBREAK) begin
            w_hit  = 1'b1;
            w_half = c_HALF_EBREAK;
        end else if (w_op == 7'b0010011 && w_f3 == 3'b000 && w_rd != 5'd0 && w_imm6_ok) begin
            if (w_rs1 == w_rd && w_imm_i != 12'd0) begin
                w_hit  = 1'b1;
                w_half = {3'b000, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
            end else if (w_rs1 == 5'd0) begin
                w_hit  = 1'b1;
                w_half = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
            end
        end else if (w_op == 7'b0110011 && w_f3 == 3'b000 && w_f7 == 7'd0 &&
                     w_rd != 5'd0 && w_rs2 != 5'd0) begin
            if (w_rs1 == 5'd0) begin
                w_hit  = 1'b1;
                w_half = {4'b1000, w_rd, w_rs2, 2'b10};
            end else if (w_rs1 == w_rd) begin
                w_hit  = 1'b1;
                w_half = {4'b1001, w_rd, w_rs2, 2'b10};
            end
        end else if (w_op == 7'b0000011 && w_rd_c && w_rs1_c) begin
            if (w_f3 == 3'b010 && w_imm_i[11:7] == 5'd0 && w_imm_i[1:0] == 2'd0) begin
                w_hit  = 1'b1;
                w_half = {3'b010, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6],
                          w_rd[2:0], 2'b00};
            end else if (w_f3 == 3'b011 && w_imm_i[11:8] == 4'd0 && w_imm_i[2:0] == 3'd0) begin
                w_hit  = 1'b1;
                w_half = {3'b011, w_imm_i[5:3], w_rs1[2:0], w_imm_i[7:6], w_rd[2:0], 2'b00};
            end
        end else if (w_op == 7'b0100011 && w_rs2_c && w_rs1_c) begin
            if (w_f3 == 3'b010 && w_imm_s[11:7] == 5'd0 && w_imm_s[1:0] == 2'd0) begin
                w_hit  = 1'b1;
                w_half = {3'b110, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6],
                          w_rs2[2:0], 2'b00};
            end else if (w_f3 == 3'b011 && w_imm_s[11:8] == 4'd0 && w_imm_s[2:0] == 3'd0) begin
                w_hit  = 1'b1;
                w_half = {3'b111, w_imm_s[5:3], w_rs1[2:0], w_imm_s[7:6], w_rs2[2:0], 2'b00};
            end
        end
    end

    assign w_slot_free = !r_out_valid_q || out_ready;
    assign in_ready    = w_slot_free && !flush;
    assign w_accept    = in_valid && in_ready;

    // Packing: merge accepted halfwords/words with the pending low halfword
    always_comb begin
        w_hold_v_d    = r_hold_v_q;
        w_hold_d      = r_hold_q;
        w_out_data_d  = r_out_data_q;
        w_out_valid_d = r_out_valid_q && !out_ready;
        w_cnt_in_d    = r_cnt_in_q;
        w_cnt_cmp_d   = r_cnt_cmp_q;
        if (w_accept) begin
            if (!(&r_cnt_in_q)) begin
                w_cnt_in_d = r_cnt_in_q + c_CNT_ONE;
            end
            if (w_hit && !(&r_cnt_cmp_q)) begin
                w_cnt_cmp_d = r_cnt_cmp_q + c_CNT_ONE;
            end
            if (w_hit) begin
                if (!r_hold_v_q) begin
                    w_hold_d   = w_half;
                    w_hold_v_d = 1'b1;
                end else begin
                    w_out_data_d  = {w_half, r_hold_q};
                    w_out_valid_d = 1'b1;
                    w_hold_v_d    = 1'b0;
                end
            end else begin
                w_out_valid_d = 1'b1;
                if (!r_hold_v_q) begin
                    w_out_data_d = in_data;
                end else begin
                    // A 32-bit instruction straddles two output words
                    w_out_data_d = {in_data[15:0], r_hold_q};
                    w_hold_d     = in_data[31:16];
                end
            end
        end else if (flush && w_slot_free && r_hold_v_q) begin
            // Pad a lone halfword with C.NOP so the word remains decodable
            w_out_data_d  = {c_HALF_NOP, r_hold_q};
            w_out_valid_d = 1'b1;
            w_hold_v_d    = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_hold_v_q    <= 1'b0;
            r_hold_q      <= 16'h0000;
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= 32'h0000_0000;
            r_cnt_in_q    <= '0;
            r_cnt_cmp_q   <= '0;
        end else begin
            r_hold_v_q    <= w_hold_v_d;
            r_hold_q      <= w_hold_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_cnt_in_q    <= w_cnt_in_d;
            r_cnt_cmp_q   <= w_cnt_cmp_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign idle      = !r_hold_v_q && !r_out_valid_q;
    assign cnt_in    = r_cnt_in_q;
    assign cnt_cmp   = r_cnt_cmp_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_compress_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_compress_pack
// Brief    : Self-checking bench for ifu_compress_pack: directed word checks,
//            then a random stream decoded back through an RVC expander.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_compress_pack;

    localparam int CNT_W = 4;
    localparam int K_INSTR = 0;
    localparam int K_RAW16 = 1;
    localparam int K_PAD   = 2;

    logic             clk = 1'b0;
    logic             rst_l = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = 32'h0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready = 1'b1;
    logic             idle;
    logic [CNT_W-1:0] cnt_in;
    logic [CNT_W-1:0] cnt_cmp;

    ifu_compress_pack #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .idle(idle),
        .cnt_in(cnt_in), .cnt_cmp(cnt_cmp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } item_t;

    int          n_checks = 0;
    int          n_err = 0;
    bit          exact_mode = 1'b1;
    bit          rand_rdy = 1'b0;
    bit          parity = 1'b0;
    int          mdl_in = 0;
    int          mdl_cmp = 0;
    logic [31:0] exp_words[$];
    item_t       items[$];
    logic [15:0] hq[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    // Spec rule set: does this 32-bit instruction have an exact RVC equivalent
    function automatic bit is_cmp(input logic [31:0] w);
        int op, rd, f3, rs1, rs2, f7, ii, is;
        op = int'(w[6:0]); rd = int'(w[11:7]); f3 = int'(w[14:12]);
        rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); f7 = int'(w[31:25]);
        ii = $signed(w[31:20]);
        is = $signed({w[31:25], w[11:7]});
        if (w == 32'h0000_0013 || w == 32'h0010_0073) return 1'b1;
        if (op == 'h13 && f3 == 0 && rd != 0 && ii >= -32 && ii <= 31) begin
            if (rs1 == rd && ii != 0) return 1'b1;
            if (rs1 == 0) return 1'b1;
        end
        if (op == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && (rs1 == 0 || rs1 == rd))
            return 1'b1;
        if (op == 'h03 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15) begin
            if (f3 == 2 && ii >= 0 && ii <= 124 && ii % 4 == 0) return 1'b1;
            if (f3 == 3 && ii >= 0 && ii <= 248 && ii % 8 == 0) return 1'b1;
        end
        if (op == 'h23 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15) begin
            if (f3 == 2 && is >= 0 && is <= 124 && is % 4 == 0) return 1'b1;
            if (f3 == 3 && is >= 0 && is <= 248 && is % 8 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // IFU-style RVC expander for the forms the packer can emit
    function automatic logic [31:0] decomp(input logic [15:0] h);
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] imm6, ow, od;
        rd = h[11:7]; rs2 = h[6:2];
        rdp = {2'b01, h[4:2]}; rs1p = {2'b01, h[9:7]};
        imm6 = {{6{h[12]}}, h[12], h[6:2]};
        ow = {5'd0, h[5], h[12:10], h[6], 2'b00};
        od = {4'd0, h[6:5], h[12:10], 3'b000};
        case ({h[15:13], h[1:0]})
            5'b000_01: return {imm6, rd, 3'b000, rd, 7'h13};
            5'b010_01: return {imm6, 5'd0, 3'b000, rd, 7'h13};
            5'b010_00: return {ow, rs1p, 3'b010, rdp, 7'h03};
            5'b011_00: return {od, rs1p, 3'b011, rdp, 7'h03};
            5'b110_00: return {ow[11:5], rdp, rs1p, 3'b010, ow[4:0], 7'h23};
            5'b111_00: return {od[11:5], rdp, rs1p, 3'b011, od[4:0], 7'h23};
            5'b100_10: begin
                if (h == 16'h9002) return 32'h0010_0073;
                if (!h[12] && rs2 != 5'd0) return {7'd0, rs2, 5'd0, 3'b000, rd, 7'h33};
                if (h[12] && rs2 != 5'd0) return {7'd0, rs2, rd, 3'b000, rd, 7'h33};
                return 32'hFFFF_FFFF;
            end
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [15:0] h;
        logic [31:0] r;
        int          off;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        imm = 12'($urandom_range(0, 80)) - 12'd40;
        case ($urandom_range(0, 9))
            0: return {imm, rd, 3'b000, rd, 7'h13};
            1: return {imm, 5'd0, 3'b000, rd, 7'h13};
            2: begin
                case ($urandom_range(0, 2))
                    0: rs1 = 5'd0;
                    1: rs1 = rd;
                    default: ;
                endcase
                f7 = ($urandom_range(0, 7) == 0) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, 3'b000, rd, 7'h33};
            end
            3, 4: begin
                rd  = 5'($urandom_range(6, 17));
                rs1 = 5'($urandom_range(6, 17));
                if ($urandom_range(0, 1) == 1) begin
                    f3 = 3'b010;
                    off = $urandom_range(0, 33) * 4 + (($urandom_range(0, 9) == 0) ? 2 : 0);
                end else begin
                    f3 = 3'b011;
                    off = $urandom_range(0, 33) * 8 + (($urandom_range(0, 9) == 0) ? 4 : 0);
                end
                imm = 12'(off);
                if ($urandom_range(0, 1) == 1) return {imm, rs1, f3, rd, 7'h03};
                return {imm[11:5], rd, rs1, f3, imm[4:0], 7'h23};
            end
            5: return ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0013;
            6: begin
                h = 16'($urandom);
                if (h[1:0] == 2'b11) h[1:0] = 2'b01;
                return {16'($urandom), h};
            end
            7: begin
                r = $urandom;
                r[1:0] = 2'b11;
                return r;
            end
            8: return {20'($urandom), rd, 7'h37};
            default: begin
                case ($urandom_range(0, 4))
                    0: imm = 12'hFDF;   // -33
                    1: imm = 12'hFE0;   // -32
                    2: imm = 12'd31;
                    3: imm = 12'd32;
                    default: imm = 12'd0;
                endcase
                return {imm, rd, 3'b000, rd, 7'h13};
            end
        endcase
    endfunction

    task automatic check_half(input logic [15:0] h);
        item_t it;
        if (items.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL sb_half_unexpected: got %h expected no output", h);
            return;
        end
        it = items.pop_front();
        if (it.kind == K_PAD) chk("pad_half", 32'(h), 32'h0001);
        else if (it.kind == K_RAW16) chk("raw_half", 32'(h), 32'(it.val[15:0]));
        else begin
            n_checks++;
            if (!is_cmp(it.val) || decomp(h) !== it.val) begin
                n_err++;
                $display("FAIL half_expand: got %h (expands to %h) expected instr %h compressible=%0d",
                         h, decomp(h), it.val, is_cmp(it.val));
            end
        end
    endtask

    task automatic check_word(input logic [31:0] w);
        item_t it;
        if (items.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL sb_word_unexpected: got %h expected no output", w);
            return;
        end
        it = items.pop_front();
        n_checks++;
        if (it.kind != K_INSTR || is_cmp(it.val) || w !== it.val) begin
            n_err++;
            $display("FAIL word_passthru: got %h expected %h kind=%0d compressible=%0d",
                     w, it.val, it.kind, is_cmp(it.val));
        end
    endtask

    // Monitor: consumes each transferred word and checks stall stability
    always @(negedge clk) begin
        if (rst_l && prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, prev_data);
        end
        if (rst_l && out_valid && out_ready) begin
            if (exact_mode) begin
                if (exp_words.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL word_unexpected: got %h expected no output", out_data);
                end else begin
                    chk("word", out_data, exp_words.pop_front());
                end
            end else begin
                hq.push_back(out_data[15:0]);
                hq.push_back(out_data[31:16]);
                while (hq.size() > 0) begin
                    if (hq[0][1:0] != 2'b11) begin
                        check_half(hq.pop_front());
                    end else if (hq.size() >= 2) begin
                        check_word({hq[1], hq[0]});
                        void'(hq.pop_front());
                        void'(hq.pop_front());
                    end else begin
                        break;
                    end
                end
            end
        end
        prev_stall = rst_l && out_valid && !out_ready;
        prev_data  = out_data;
    end

    // Random backpressure during the random phase
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic send(input logic [31:0] w, output int waited);
        bit acc;
        item_t it;
        in_valid = 1'b1;
        in_data  = w;
        waited   = 0;
        acc      = 1'b0;
        while (!acc) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else begin
                waited++;
                if (waited >= 200) begin
                    n_checks++; n_err++;
                    $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected accept of %h", w);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        mdl_in++;
        it.val  = w;
        it.kind = (w[1:0] != 2'b11) ? K_RAW16 : K_INSTR;
        if (w[1:0] != 2'b11 || is_cmp(w)) begin
            mdl_cmp++;
            parity = ~parity;
        end
        if (!exact_mode) items.push_back(it);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        int n;
        item_t it;
        if (!exact_mode && parity) begin
            it.kind = K_PAD;
            it.val  = 32'h0001;
            items.push_back(it);
        end
        parity = 1'b0;
        flush = 1'b1;
        n = 0;
        @(negedge clk);
        chk("flush_blocks_in", 32'(in_ready), 32'd0);
        while (!idle && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("flush_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
        mdl_in = 0; mdl_cmp = 0; parity = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_cnt_in", 32'(cnt_in), 32'd0);
        chk("rst_cnt_cmp", 32'(cnt_cmp), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int wt;
        #1;
        do_reset();
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;

        // Two compressed instructions form one word
        out_ready = 1'b1;
        exp_words.push_back(32'h852E_0405);
        send(32'h0014_0413, wt);
        chk("hold_no_out", 32'(out_valid), 32'd0);
        chk("hold_not_idle", 32'(idle), 32'd0);
        send(32'h00B0_0533, wt);
        chk("latency_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("pair_idle", 32'(idle), 32'd1);
        chk("pair_cnt_in", 32'(cnt_in), 32'd2);
        chk("pair_cnt_cmp", 32'(cnt_cmp), 32'd2);
        @(posedge clk); #1;

        // Straddling 32-bit instruction, then flush pads with C.NOP
        exp_words.push_back(32'h0093_0405);
        exp_words.push_back(32'h0001_0641);
        send(32'h0014_0413, wt);
        send(32'h0641_0093, wt);
        do_flush();

        // Backpressure holds output; boundary encodings
        out_ready = 1'b0;
        exp_words.push_back(32'h0204_0413);   // addi x8,x8,32 stays 32-bit
        send(32'h0204_0413, wt);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_data", out_data, 32'h0204_0413);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'hFE04_0413, wt);              // addi x8,x8,-32 -> 0x1401
        chk("bp_same_cycle_accept", 32'(wt), 32'd0);
        exp_words.push_back(32'h7D64_1401);   // ld x9,248(x10) -> 0x7D64
        send(32'h0F85_3483, wt);
        exp_words.push_back(32'h1005_3483);   // ld offset 256 stays 32-bit
        send(32'h1005_3483, wt);
        exp_words.push_back(32'h0001_9002);   // ebreak -> 0x9002, padded
        send(32'h0010_0073, wt);
        do_flush();
        chk("dir_drained", 32'(exp_words.size()), 32'd0);
        chk("dir_cnt_in", 32'(cnt_in), 32'(sat(mdl_in)));
        chk("dir_cnt_cmp", 32'(cnt_cmp), 32'(sat(mdl_cmp)));

        // Mid-stream reset discards the held halfword and the pending word
        out_ready = 1'b0;
        send(32'h0014_0413, wt);
        send(32'h0641_0093, wt);
        do_reset();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;

        // Random stream with random backpressure and occasional flushes
        exact_mode = 1'b0;
        rand_rdy   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_flush();
            send(gen_instr(), wt);
        end
        do_flush();
        rand_rdy = 1'b0;
        chk("rand_items_left", 32'(items.size()), 32'd0);
        chk("rand_halves_left", 32'(hq.size()), 32'd0);
        chk("sat_cnt_in", 32'(cnt_in), 32'(sat(mdl_in)));
        chk("sat_cnt_cmp", 32'(cnt_cmp), 32'(sat(mdl_cmp)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ifu_compress_pack.md
# ifu_compress_pack

Compression packer: inverse of the IFU's 16→32 RVC expander. Accepts a stream of 32-bit RV64 instructions, re-encodes each one that has an exact 16-bit RVC equivalent, and packs the resulting halfwords little-endian into 32-bit words for instruction memory image generation and for compressed-fetch stress streams. Every emitted halfword must expand through the IFU's decompressor to the accepted 32-bit instruction.

## Interface
- CNT_W, 16, width of the saturating statistics counters
- clk  in  1  clock
- rst_l  in  1  reset; synchronous, active-low
- in_valid  in  1  instruction offered
- in_data  in  32  instruction; if in_data[1:0]!=2'b11 it is already compressed and only [15:0] is used
- in_ready  out  1  instruction accepted on in_valid & in_ready
- flush  in  1  level request to pad and emit any pending halfword
- out_valid  out  1  packed word available
- out_data  out  32  packed word; bits [15:0] hold the earlier halfword
- out_ready  in  1  consumer takes word on out_valid & out_ready
- idle  out  1  no pending halfword and no pending output
- cnt_in  out  CNT_W  instructions accepted, saturating
- cnt_cmp  out  CNT_W  instructions emitted as 16-bit, saturating

## Operation
- Compressor (combinational; match only under exactly these conditions, otherwise emit unchanged as 32-bit):
  - addi x0,x0,0 → C.NOP 0x0001
  - addi rd,rd,imm, rd!=0, imm in [-32,31], imm!=0 → C.ADDI
  - addi rd,x0,imm, rd!=0, imm in [-32,31] → C.LI
  - add rd,x0,rs2, rd!=0, rs2!=0 → C.MV
  - add rd,rd,rs2, rd!=0, rs2!=0 → C.ADD
  - lw/sw with rd/rs2 and rs1 in x8–x15, offset 0–124, multiple of 4 → C.LW/C.SW
  - ld/sd with the same register rule, offset 0–248, multiple of 8 → C.LD/C.SD
  - ebreak 0x00100073 → C.EBREAK 0x9002
  - any other instruction, including the C.ADDI4SPN, C.ADDI16SP, SP-relative and branch forms → no match
- State: hold_v (1 bit) and hold[15:0] (pending low halfword).
- slot_free = !out_valid | out_ready
- in_ready = slot_free & !flush (combinational)
- Accept of compressed halfword c:
  - if !hold_v: hold<=c, hold_v<=1, no output.
  - if hold_v: out_data<={c,hold}, out_valid<=1, hold_v<=0.
- Accept of uncompressed word w:
  - if !hold_v: out_data<=w, out_valid<=1.
  - if hold_v: out_data<={w[15:0],hold}, out_valid<=1, hold<=w[31:16], hold_v stays 1.
- Flush, evaluated when flush & slot_free:
  - if hold_v: out_data<={16'h0001,hold}, out_valid<=1, hold_v<=0.
  - if !hold_v: no action.
  - flush blocks input, so input and flush never act in the same cycle.
- If out_valid & out_ready and nothing new is produced, out_valid<=0 and out_data holds its value.
- idle = !hold_v & !out_valid.
- Counters:
  - cnt_in increments on every accept.
  - cnt_cmp increments on every accept that yields a halfword, including pre-compressed input.
  - Both saturate at all-ones.

## Timing
- Reset values: out_valid=0, out_data=0, hold_v=0, hold=0, cnt_in=0, cnt_cmp=0, idle=1. in_ready=1 when flush=0.
- Latency: the word completed by an accept appears on out_data/out_valid in the next cycle.
- Throughput: one instruction per cycle while out_ready=1. The output register is a single stage; a new word may be loaded in the same cycle the old one is taken.
- out_ready=0 while out_valid=1 forces in_ready=0. out_data must stay stable until taken.
- A reset asserted mid-stream discards hold and any pending output.
- flush and in_valid asserted together: flush wins and the instruction waits.

## Test plan
- Reset: hold rst_l=0 for 2 cycles, then release → out_valid=0, idle=1, counters 0, in_ready=1.
- Two compressed instructions: 0x00140413 (addi x8,x8,1 → 0x0405), then 0x00B00533 (mv a0,a1 → 0x852E) → one word 0x852E0405 one cycle after the second accept; cnt_in=2, cnt_cmp=2, idle=1 after it is taken.
- Straddle: 0x00140413, then 0x06410093 (not compressible) → 0x00930405 and hold=0x0641; then flush=1 → 0x00010641, idle=1.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0 and out_data stable for 5 cycles; set out_ready=1 → transfer, next accept the same cycle.
- Boundaries:
  - addi x8,x8,32 (0x02040413) → passes through as 32-bit.
  - addi x8,x8,-32 (0xFE040413) → compressed to C.ADDI 0x1401.
  - ld x9,248(x10) (0x0F853483) → C.LD.
  - ld offset 256 → passes through as 32-bit.
  - ebreak → 0x9002.
- Cross-check: random legal instruction stream with random out_ready, each emitted halfword fed through the IFU decompressor → must reproduce the accepted 32-bit instruction. Counter saturation checked with CNT_W=4.
